flag_branch_unit: RTL and testbench

//  Downstream consumer of the ALU's Z/V/N flags. Holds the architectural flag register with per-opcode

---
 rtl/flag_branch_unit.sv | 88 ++++++++
 tb/tb_flag_branch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register with EX bypass, plus B/BR condition resolve and PC redirect.
// Latency: flags update on the write edge; redirect_valid/redirect_pc appear one cycle after resolve.
// Backpressure: stall freezes flag writes and resolution, drops redirect_valid; decode re-presents.
module flag_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [2:0]        alu_flags,
  input  logic              ex_flush,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [2:0]        id_cond,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [ADDR_W-1:0] id_pc_plus2,
  input  logic [ADDR_W-1:0] id_rs_val,
  output logic [2:0]        flags_q,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [3:0] OP_B  = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;

  logic [2:0]        wr_mask;
  logic              wr_en;
  logic [2:0]        eff_flags;
  logic              eff_z, eff_v, eff_n;
  logic              cond_true;
  logic              is_branch;
  logic              resolve;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] target;

  always_comb begin
    wr_mask = 3'b000;
    case (ex_opcode)
      4'b0000, 4'b0001:                   wr_mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_mask = 3'b100;
      default:                            wr_mask = 3'b000;
    endcase
  end

  assign wr_en     = ex_valid & ~ex_flush & ~stall;
  // Bypass: a branch in decode sees the flags EX is about to write this edge.
  assign eff_flags = wr_en ? ((flags_q & ~wr_mask) | (alu_flags & wr_mask)) : flags_q;
  assign eff_z     = eff_flags[2];
  assign eff_v     = eff_flags[1];
  assign eff_n     = eff_flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (id_cond)
      3'b000:  cond_true = ~eff_z;
      3'b001:  cond_true = eff_z;
      3'b010:  cond_true = ~eff_z & ~eff_n;
      3'b011:  cond_true = eff_n;
      3'b100:  cond_true = eff_z | ~eff_n;
      3'b101:  cond_true = eff_z | eff_n;
      3'b110:  cond_true = eff_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign is_branch = (id_opcode == OP_B) | (id_opcode == OP_BR);
  // Decode is wrong-path while a redirect is in flight.
  assign resolve   = id_valid & ~stall & ~redirect_valid & is_branch & cond_true;
  assign imm_sext  = {{(ADDR_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
  assign target    = (id_opcode == OP_BR) ? id_rs_val
                                          : id_pc_plus2 + {imm_sext[ADDR_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q        <= 3'b000;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (wr_en) flags_q <= eff_flags;
      redirect_valid <= resolve;
      if (resolve) redirect_pc <= target;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed scenarios plus randomized traffic checked against a behavioural model of the flag/branch rules.
module tb_flag_branch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_flush, stall, id_valid;
  logic [3:0]  ex_opcode, id_opcode;
  logic [2:0]  alu_flags, id_cond;
  logic [8:0]  id_imm;
  logic [15:0] id_pc_plus2, id_rs_val;
  logic [2:0]  flags_q;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: flags as separate booleans, last redirect state.
  bit m_z, m_v, m_n;
  bit m_rv;
  int m_pc;

  flag_branch_unit #(.ADDR_W(16), .IMM_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .alu_flags(alu_flags), .ex_flush(ex_flush),
    .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
    .id_imm(id_imm), .id_pc_plus2(id_pc_plus2), .id_rs_val(id_rs_val),
    .flags_q(flags_q), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_flush = 0; stall = 0; id_valid = 0;
    ex_opcode = 4'b0011; alu_flags = 3'b000; id_opcode = 4'b0000; id_cond = 3'b000;
    id_imm = '0; id_pc_plus2 = '0; id_rs_val = '0;
  endtask

  task automatic model_reset();
    m_z = 0; m_v = 0; m_n = 0; m_rv = 0; m_pc = 0;
  endtask

  // Advance model by one edge using current driven inputs, then compare after the edge.
  task automatic step(input string tag);
    bit wr, wz, wvn, z, v, n, taken, res;
    int simm, tgt;
    wr  = ex_valid && !ex_flush && !stall;
    wz  = ex_opcode inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    wvn = ex_opcode inside {4'd0, 4'd1};
    z = (wr && wz)  ? alu_flags[2] : m_z;
    v = (wr && wvn) ? alu_flags[1] : m_v;
    n = (wr && wvn) ? alu_flags[0] : m_n;
    case (id_cond)
      3'd0: taken = !z;
      3'd1: taken = z;
      3'd2: taken = !z && !n;
      3'd3: taken = n;
      3'd4: taken = z || !n;
      3'd5: taken = z || n;
      3'd6: taken = v;
      default: taken = 1;
    endcase
    res  = id_valid && !stall && !m_rv && (id_opcode == 4'd12 || id_opcode == 4'd13) && taken;
    simm = id_imm[8] ? int'(id_imm) - 512 : int'(id_imm);
    tgt  = (id_opcode == 4'd13) ? int'(id_rs_val) : ((int'(id_pc_plus2) + 2 * simm) & 32'hFFFF);
    m_z = z; m_v = v; m_n = n;
    m_rv = res;
    if (res) m_pc = tgt;
    @(posedge clk);
    #1;
    check({tag, ".flags"}, {29'd0, flags_q}, {29'd0, m_z, m_v, m_n});
    check({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, m_rv});
    check({tag, ".pc"}, {16'd0, redirect_pc}, m_pc);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12;
    check("rst.flags", {29'd0, flags_q}, 32'd0);
    check("rst.rv", {31'd0, redirect_valid}, 32'd0);
    check("rst.pc", {16'd0, redirect_pc}, 32'd0);
    @(negedge clk); rst_n = 1;

    // SUB sets Z, B EQ in the same cycle uses bypassed flags.
    @(negedge clk); idle();
    ex_valid = 1; ex_opcode = 4'd1; alu_flags = 3'b100;
    id_valid = 1; id_opcode = 4'd12; id_cond = 3'd1; id_pc_plus2 = 16'h0010; id_imm = 9'h1FD;
    step("sub_beq");
    check("sub_beq.pc_const", {16'd0, redirect_pc}, 32'h000A);
    check("sub_beq.flags_const", {29'd0, flags_q}, 32'd4);

    // Load 101, then XOR writes Z only.
    @(negedge clk); idle(); ex_valid = 1; ex_opcode = 4'd0; alu_flags = 3'b101;
    step("add_set");
    @(negedge clk); idle(); ex_valid = 1; ex_opcode = 4'd2; alu_flags = 3'b010;
    step("xor_z");
    check("xor_z.const", {29'd0, flags_q}, 32'd1);

    // Flushed ADD must not write nor bypass; OV branch not taken.
    @(negedge clk); idle(); ex_valid = 1; ex_flush = 1; ex_opcode = 4'd0; alu_flags = 3'b010;
    id_valid = 1; id_opcode = 4'd12; id_cond = 3'd6; id_pc_plus2 = 16'h0200;
    step("flush_ov");
    check("flush_ov.rv_const", {31'd0, redirect_valid}, 32'd0);
    check("flush_ov.flags_const", {29'd0, flags_q}, 32'd1);

    // Wrap target, then back-to-back branch in the shadow is ignored.
    @(negedge clk); idle(); id_valid = 1; id_opcode = 4'd12; id_cond = 3'd7;
    id_pc_plus2 = 16'hFFFE; id_imm = 9'd1;
    step("wrap");
    check("wrap.rv_const", {31'd0, redirect_valid}, 32'd1);
    check("wrap.pc_const", {16'd0, redirect_pc}, 32'h0000);
    @(negedge clk); id_pc_plus2 = 16'h0100;
    step("shadow");
    check("shadow.rv_const", {31'd0, redirect_valid}, 32'd0);

    // BR held under stall, redirects one cycle after release.
    @(negedge clk); idle(); id_valid = 1; id_opcode = 4'd13; id_cond = 3'd7;
    id_rs_val = 16'h1234; stall = 1;
    step("stall0");
    @(negedge clk); step("stall1");
    @(negedge clk); stall = 0;
    step("release");
    check("release.pc_const", {16'd0, redirect_pc}, 32'h1234);

    // Async reset mid-cycle while a redirect is pending.
    @(negedge clk); idle(); ex_valid = 1; ex_opcode = 4'd0; alu_flags = 3'b111;
    id_valid = 1; id_opcode = 4'd12; id_cond = 3'd7; id_pc_plus2 = 16'h0040;
    step("pre_rst");
    #2 rst_n = 0;
    #1;
    model_reset();
    check("arst.flags", {29'd0, flags_q}, 32'd0);
    check("arst.rv", {31'd0, redirect_valid}, 32'd0);
    check("arst.pc", {16'd0, redirect_pc}, 32'd0);
    @(negedge clk); rst_n = 1; idle();

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      ex_valid    = $urandom_range(0, 3) != 0;
      ex_opcode   = 4'($urandom_range(0, 15));
      alu_flags   = 3'($urandom);
      ex_flush    = $urandom_range(0, 7) == 0;
      stall       = $urandom_range(0, 7) == 0;
      id_valid    = $urandom_range(0, 3) != 0;
      id_opcode   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(12, 13)) : 4'($urandom_range(0, 15));
      id_cond     = 3'($urandom);
      id_imm      = 9'($urandom);
      id_pc_plus2 = 16'($urandom);
      id_rs_val   = 16'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
